// File: rtl/thr_stream_stage.sv
// Per-pixel threshold stage: maps gradient magnitudes to output pixels (clamp, binary or
// dual-threshold) behind a valid/ready handshake, counts a programmed number of pixels per
// frame and reports frame completion together with the number of nonzero pixels emitted.
module thr_stream_stage #(
    parameter int unsigned MAG_W    = 16,
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned CNT_W    = 21,
    parameter int unsigned WEAK_VAL = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] thr_low,
    input  logic [PIX_W-1:0] thr_high,
    input  logic [CNT_W-1:0] total_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] magnitude,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] pixel_out,
    output logic             busy,
    output logic             thr_done,
    output logic [CNT_W-1:0] edge_count
);

    localparam logic [PIX_W-1:0] PixMax    = '1;
    localparam logic [MAG_W-1:0] PixMaxExt = MAG_W'(PixMax);
    localparam logic [PIX_W-1:0] WeakPix   = PIX_W'(WEAK_VAL);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [PIX_W-1:0] thr_low_q, thr_low_d;
    logic [PIX_W-1:0] thr_high_q, thr_high_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic             thr_done_q, thr_done_d;

    logic             in_hs, out_hs, pixel_nz;
    logic [CNT_W-1:0] in_cnt_inc, out_cnt_inc, acc_inc;
    logic [PIX_W-1:0] sat, pix_calc;
    logic             pass_low, pass_high;

    // Pixel mapping from the configuration latched at start
    always_comb begin
        sat       = (magnitude > PixMaxExt) ? PixMax : magnitude[PIX_W-1:0];
        pass_low  = magnitude >= MAG_W'(thr_low_q);
        pass_high = magnitude >= MAG_W'(thr_high_q);
        pix_calc  = '0;
        case (mode_q)
            2'd1: begin
                if (pass_low) pix_calc = PixMax;
            end
            2'd2: begin
                // thr_low > thr_high leaves the weak band empty without special casing
                if (pass_high)     pix_calc = PixMax;
                else if (pass_low) pix_calc = WeakPix;
            end
            default: begin
                if (pass_low) pix_calc = sat;
            end
        endcase
    end

    // Handshakes and outputs; in_ready is the only output-to-input combinational path
    always_comb begin
        in_ready    = (state_q == StRun) && (!out_valid_q || out_ready);
        in_hs       = in_valid && in_ready;
        out_hs      = out_valid_q && out_ready;
        pixel_nz    = (pixel_q != '0);
        in_cnt_inc  = in_cnt_q + CNT_W'(1);
        out_cnt_inc = out_cnt_q + CNT_W'(1);
        acc_inc     = acc_q + CNT_W'(pixel_nz);
        out_valid   = out_valid_q;
        pixel_out   = pixel_q;
        busy        = (state_q == StRun) || (state_q == StDrain);
        thr_done    = thr_done_q;
        edge_count  = edge_count_q;
    end

    // Next-state: start overrides any same-cycle handshake
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        thr_low_d    = thr_low_q;
        thr_high_d   = thr_high_q;
        total_d      = total_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        acc_d        = acc_q;
        edge_count_d = edge_count_q;
        out_valid_d  = out_valid_q;
        pixel_d      = pixel_q;
        thr_done_d   = thr_done_q;

        if (start) begin
            mode_d      = mode;
            thr_low_d   = thr_low;
            thr_high_d  = thr_high;
            total_d     = total_pixel;
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            acc_d       = '0;
            thr_done_d  = 1'b0;
            out_valid_d = 1'b0;
            if (total_pixel == '0) begin
                state_d      = StDone;
                thr_done_d   = 1'b1;
                edge_count_d = '0;
            end else begin
                state_d = StRun;
            end
        end else begin
            if (out_hs) begin
                out_valid_d = 1'b0;
                out_cnt_d   = out_cnt_inc;
                acc_d       = acc_inc;
                if (out_cnt_inc == total_q) begin
                    state_d      = StDone;
                    thr_done_d   = 1'b1;
                    edge_count_d = acc_inc;
                end
            end
            // Completion needs every input accepted, so it never coincides with in_hs
            if (in_hs) begin
                out_valid_d = 1'b1;
                pixel_d     = pix_calc;
                in_cnt_d    = in_cnt_inc;
                if (in_cnt_inc == total_q) state_d = StDrain;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            mode_q       <= 2'd0;
            thr_low_q    <= '0;
            thr_high_q   <= '0;
            total_q      <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            acc_q        <= '0;
            edge_count_q <= '0;
            out_valid_q  <= 1'b0;
            pixel_q      <= '0;
            thr_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            thr_low_q    <= thr_low_d;
            thr_high_q   <= thr_high_d;
            total_q      <= total_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            acc_q        <= acc_d;
            edge_count_q <= edge_count_d;
            out_valid_q  <= out_valid_d;
            pixel_q      <= pixel_d;
            thr_done_q   <= thr_done_d;
        end
    end

endmodule

// File: tb/tb_thr_stream_stage.sv
// Directed bench for thr_stream_stage: inputs change on the falling edge, outputs are
// sampled on the falling edge, expected values are written out by hand.
module tb_thr_stream_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  thr_low;
    logic [7:0]  thr_high;
    logic [20:0] total_pixel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] magnitude;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  pixel_out;
    logic        busy;
    logic        thr_done;
    logic [20:0] edge_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned mag_v[8];
    int unsigned exp_v[8];

    thr_stream_stage #(
        .MAG_W(16), .PIX_W(8), .CNT_W(21), .WEAK_VAL(128)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .thr_low(thr_low),
        .thr_high(thr_high), .total_pixel(total_pixel), .in_valid(in_valid),
        .in_ready(in_ready), .magnitude(magnitude), .out_valid(out_valid),
        .out_ready(out_ready), .pixel_out(pixel_out), .busy(busy), .thr_done(thr_done),
        .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulse start at a falling edge, then scramble the config to show it is ignored later
    task automatic start_frame(input logic [1:0] m, input int lo, input int hi, input int tot);
        mode        = m;
        thr_low     = 8'(lo);
        thr_high    = 8'(hi);
        total_pixel = 21'(tot);
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        mode        = ~m;
        thr_low     = ~thr_low;
        thr_high    = ~thr_high;
        total_pixel = 21'd1;
    endtask

    // Back-to-back beats with out_ready high; each pixel checked one cycle after accept
    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            magnitude = 16'(mag_v[i]);
            #1;
            check_eq("in_ready", in_ready, 1);
            @(negedge clk);
            check_eq("out_valid", out_valid, 1);
            check_eq("pixel_out", pixel_out, exp_v[i]);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_done(input int edges);
        @(negedge clk);
        check_eq("thr_done", thr_done, 1);
        check_eq("busy_done", busy, 0);
        check_eq("out_valid_done", out_valid, 0);
        check_eq("edge_count", edge_count, 32'(edges));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; mode = 2'd0; thr_low = 8'd0; thr_high = 8'd0;
        total_pixel = 21'd0; in_valid = 1'b0; magnitude = 16'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_pixel", pixel_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_thr_done", thr_done, 0);
        check_eq("rst_edge_count", edge_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Clamp mode
        start_frame(2'd0, 50, 0, 4);
        check_eq("busy_run", busy, 1);
        check_eq("thr_done_run", thr_done, 0);
        mag_v[0:3] = '{10, 50, 300, 255};
        exp_v[0:3] = '{0, 50, 255, 255};
        stream(4);
        expect_done(3);
        @(negedge clk);
        check_eq("thr_done_sticky", thr_done, 1);

        // Binary mode
        start_frame(2'd1, 100, 0, 2);
        check_eq("thr_done_cleared", thr_done, 0);
        mag_v[0:1] = '{99, 100};
        exp_v[0:1] = '{0, 255};
        stream(2);
        expect_done(1);

        // Dual-threshold mode
        start_frame(2'd2, 40, 200, 5);
        mag_v[0:4] = '{39, 40, 199, 200, 65535};
        exp_v[0:4] = '{0, 128, 128, 255, 255};
        stream(5);
        expect_done(4);

        // Reserved mode behaves as clamp; thr_low=0 passes everything, zero is not an edge
        start_frame(2'd3, 0, 0, 2);
        mag_v[0:1] = '{0, 7};
        exp_v[0:1] = '{0, 7};
        stream(2);
        expect_done(1);

        // Inverted thresholds: no weak band
        start_frame(2'd2, 200, 100, 2);
        mag_v[0:1] = '{150, 50};
        exp_v[0:1] = '{255, 0};
        stream(2);
        expect_done(1);

        // Back-pressure: pixel 5 held for five cycles, then 6 and 7 flow
        start_frame(2'd0, 0, 0, 3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        magnitude = 16'd5;
        @(negedge clk);
        magnitude = 16'd6;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_pixel", pixel_out, 5);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", in_ready, 1);
        @(negedge clk);
        check_eq("bp_pixel6", pixel_out, 6);
        magnitude = 16'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_pixel7", pixel_out, 7);
        check_eq("drain_busy", busy, 1);
        check_eq("drain_in_ready", in_ready, 0);
        expect_done(3);

        // Restart mid-frame: pending pixel and same-cycle handshakes are dropped
        start_frame(2'd0, 0, 0, 4);
        mag_v[0:1] = '{1, 2};
        exp_v[0:1] = '{1, 2};
        stream(2);
        in_valid  = 1'b1;
        magnitude = 16'd3;
        start_frame(2'd0, 0, 0, 4);
        in_valid = 1'b0;
        check_eq("restart_out_valid", out_valid, 0);
        check_eq("restart_busy", busy, 1);
        check_eq("restart_edge_hold", edge_count, 3);
        mag_v[0:3] = '{0, 9, 0, 4};
        exp_v[0:3] = '{0, 9, 0, 4};
        stream(4);
        expect_done(2);

        // Zero-length frame
        start_frame(2'd0, 0, 0, 0);
        check_eq("zero_thr_done", thr_done, 1);
        check_eq("zero_edge_count", edge_count, 0);
        check_eq("zero_busy", busy, 0);
        @(negedge clk);
        check_eq("zero_busy_later", busy, 0);

        // Asynchronous reset while draining
        start_frame(2'd0, 0, 0, 2);
        mag_v[0:1] = '{3, 4};
        exp_v[0:1] = '{3, 4};
        stream(2);
        out_ready = 1'b0;
        #1;
        check_eq("pre_rst_busy", busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_pixel", pixel_out, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_in_ready", in_ready, 0);
        check_eq("arst_edge_count", edge_count, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start_frame(2'd1, 10, 0, 2);
        mag_v[0:1] = '{5, 10};
        exp_v[0:1] = '{0, 255};
        stream(2);
        expect_done(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
